// File: rtl/led_pattern_pkg.sv
// Shared types for the LED pattern generator: pattern modes and bounce direction.
package led_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_BINARY  = 2'd0,
    MODE_CHASE   = 2'd1,
    MODE_BREATHE = 2'd2,
    MODE_OFF     = 2'd3
  } mode_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/led_prescaler.sv
// Programmable step-tick prescaler: period = 2^(PRESCALE_W-speed_eff) clocks,
// with speed clamped so the period never drops below 2 clocks.
module led_prescaler
  import led_pattern_pkg::*;
#(
  parameter int PRESCALE_W = 23
) (
  input  logic       clk50,
  input  logic       rst_n,
  input  logic [3:0] speed,
  output logic       tick
);

  localparam int SMAX = PRESCALE_W - 1;

  logic [3:0]            speed_eff;
  logic [PRESCALE_W-1:0] term;
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic                  tick_q, tick_d;

  // Clamp speed and derive terminal count 2^(W-s)-1 as all-ones shifted right.
  always_comb begin
    speed_eff = speed;
    if (int'(speed) > SMAX) speed_eff = 4'(SMAX);
    term = {PRESCALE_W{1'b1}} >> speed_eff;
  end

  // >= rather than == so a mid-count speed increase wraps immediately.
  always_comb begin
    tick_d  = (presc_q >= term);
    presc_d = tick_d ? '0 : presc_q + 1'b1;
  end

  // Counter and registered strobe.
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-mode LED pattern generator (binary count, bouncing chase, PWM breathe, off).
// Optional BREATHE_GAMMA_EN: squares the breathe duty for a perceptual curve,
// registered, adding one clock of latency.
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int N_LEDS     = 6,
  parameter int PRESCALE_W = 23,
  parameter int PWM_W      = 8
) (
  input  logic              clk50,
  input  logic              rst_n,
  input  logic [1:0]        mode,
  input  logic [3:0]        speed,
  output logic [N_LEDS-1:0] leds,
  output logic              blink,
  output logic              tick
);

  localparam int                POS_W    = $clog2(N_LEDS);
  localparam logic [POS_W-1:0]  POS_LAST = POS_W'(N_LEDS - 1);
  localparam logic [PWM_W-1:0]  DUTY_MAX = '1;
  localparam logic [N_LEDS-1:0] LED_ONE  = N_LEDS'(1);

  logic              tick_w;
  mode_e             mode_q;
  logic              mode_chg;
  logic [N_LEDS-1:0] step_q, step_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic              dir_q, dir_d;
  logic [PWM_W-1:0]  duty_q, duty_d;
  logic [PWM_W-1:0]  pwm_q;
  logic [PWM_W-1:0]  duty_eff;
  logic [N_LEDS-1:0] leds_q, leds_d;
  logic              blink_q, blink_d;

  led_prescaler #(.PRESCALE_W(PRESCALE_W)) u_presc (
    .clk50 (clk50),
    .rst_n (rst_n),
    .speed (speed),
    .tick  (tick_w)
  );

  assign mode_chg = (mode_e'(mode) != mode_q);

  // Step/pattern advance; a mode change clears to origin and swallows a same-cycle tick.
  always_comb begin
    step_d  = step_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
    duty_d  = duty_q;
    blink_d = blink_q;
    if (mode_chg) begin
      step_d = '0;
      pos_d  = '0;
      dir_d  = DIR_UP;
      duty_d = '0;
    end else if (tick_w) begin
      step_d = step_q + 1'b1;
      if (&step_q) blink_d = ~blink_q;
      case (mode_q)
        MODE_CHASE: begin
          if (dir_q == DIR_UP) begin
            if (pos_q == POS_LAST) begin
              dir_d = DIR_DOWN;
              pos_d = POS_LAST - 1'b1;
            end else pos_d = pos_q + 1'b1;
          end else begin
            if (pos_q == '0) begin
              dir_d = DIR_UP;
              pos_d = POS_W'(1);
            end else pos_d = pos_q - 1'b1;
          end
        end
        MODE_BREATHE: begin
          if (dir_q == DIR_UP) begin
            if (duty_q == DUTY_MAX) begin
              dir_d  = DIR_DOWN;
              duty_d = DUTY_MAX - 1'b1;
            end else duty_d = duty_q + 1'b1;
          end else begin
            if (duty_q == '0) begin
              dir_d  = DIR_UP;
              duty_d = PWM_W'(1);
            end else duty_d = duty_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef BREATHE_GAMMA_EN
  logic [2*PWM_W-1:0] duty_sq;
  logic [PWM_W-1:0]   duty_eff_q;

  assign duty_sq = {{PWM_W{1'b0}}, duty_q} * {{PWM_W{1'b0}}, duty_q};

  // Registered squaring curve keeps the multiplier off the PWM compare path.
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) duty_eff_q <= '0;
    else        duty_eff_q <= PWM_W'(duty_sq >> PWM_W);
  end

  assign duty_eff = duty_eff_q;
`else
  assign duty_eff = duty_q;
`endif

  // Pattern decode from current mode and state; registered into leds_q.
  always_comb begin
    leds_d = '0;
    case (mode_q)
      MODE_BINARY:  leds_d = step_q;
      MODE_CHASE:   leds_d = LED_ONE << pos_q;
      MODE_BREATHE: leds_d = {N_LEDS{pwm_q < duty_eff}};
      default:      leds_d = '0;
    endcase
  end

  // Pattern state, free-running PWM counter and output registers.
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= MODE_BINARY;
      step_q  <= '0;
      pos_q   <= '0;
      dir_q   <= DIR_UP;
      duty_q  <= '0;
      pwm_q   <= '0;
      leds_q  <= '0;
      blink_q <= 1'b0;
    end else begin
      mode_q  <= mode_e'(mode);
      step_q  <= step_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      duty_q  <= duty_d;
      pwm_q   <= pwm_q + 1'b1;
      leds_q  <= leds_d;
      blink_q <= blink_d;
    end
  end

  assign leds  = leds_q;
  assign blink = blink_q;
  assign tick  = tick_w;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen (N_LEDS=4, PRESCALE_W=4, PWM_W=4): scoreboard of
// per-tick expectations from an arithmetic pattern model, plus directed edge cases.
module tb_led_pattern_gen;
  import led_pattern_pkg::*;

  logic       clk50 = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] mode  = MODE_BINARY;
  logic [3:0] speed = 4'd0;
  logic [3:0] leds;
  logic       blink;
  logic       tick;

  led_pattern_gen #(.N_LEDS(4), .PRESCALE_W(4), .PWM_W(4)) dut (
    .clk50 (clk50),
    .rst_n (rst_n),
    .mode  (mode),
    .speed (speed),
    .leds  (leds),
    .blink (blink),
    .tick  (tick)
  );

  always #5 clk50 = ~clk50;

  // kind 0: leds (and blink if bl>=0) two cycles after a tick; kind 1: high count of a breathe window
  typedef struct {
    int kind;
    int val;
    int bl;
  } exp_t;

  exp_t sb_q[$];
  int   total   = 0;
  int   bad     = 0;
  bit   mon_en  = 1'b0;
  int   exp_gap = 16;

`ifdef BREATHE_GAMMA_EN
  localparam int BR_LAG = 3;
`else
  localparam int BR_LAG = 2;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
    end
  endtask

  function automatic int gap_of(input int sp);
    return 16 >> ((sp > 3) ? 3 : sp);
  endfunction

  // Chase position after k ticks: triangle wave over 0..3 with period 6.
  function automatic int chase_leds(input int k);
    int p;
    p = k % 6;
    return 1 << ((p <= 3) ? p : 6 - p);
  endfunction

  // Breathe duty after k ticks: triangle over 0..15 with period 30.
  function automatic int breathe_eff(input int k);
    int p, d;
    p = k % 30;
    d = (p <= 15) ? p : 30 - p;
`ifdef BREATHE_GAMMA_EN
    d = (d * d) >> 4;
`endif
    return d;
  endfunction

  task automatic push(input int kind, input int val, input int bl);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    e.bl   = bl;
    sb_q.push_back(e);
  endtask

  // Monitor: checks tick spacing, and pops expectations a fixed lag after each tick.
  initial begin
    bit [2:0] hist;
    int       since;
    bit       gap_ok;
    bit       win_open;
    int       win_cnt;
    exp_t     e;
    hist = '0; since = 0; gap_ok = 1'b0; win_open = 1'b0; win_cnt = 0;
    forever begin
      @(negedge clk50);
      if (!mon_en) begin
        hist = '0; since = 0; gap_ok = 1'b0; win_open = 1'b0;
      end else begin
        since++;
        if (tick) begin
          if (gap_ok) chk("tick_gap", since, exp_gap);
          gap_ok = 1'b1;
          since  = 0;
        end
        if (sb_q.size() > 0) begin
          e = sb_q[0];
          if (e.kind == 0 && hist[1]) begin
            void'(sb_q.pop_front());
            chk("leds", leds, e.val);
            if (e.bl >= 0) chk("blink", blink, e.bl);
          end else if (e.kind == 1 && hist[BR_LAG-1]) begin
            if (win_open) begin
              void'(sb_q.pop_front());
              chk("duty_win", win_cnt, e.val);
            end
            win_open = 1'b1;
            win_cnt  = 0;
          end
        end
        if (win_open) begin
          win_cnt += int'(leds[0]);
          chk("leds_uniform", (leds == 4'h0 || leds == 4'hF), 1);
        end
        hist = {hist[1:0], tick};
      end
    end
  end

  task automatic drain(input int bound);
    for (int i = 0; i < bound && sb_q.size() != 0; i++) @(posedge clk50);
    #1;
    chk("sb_drain", sb_q.size(), 0);
    sb_q.delete();
    mon_en = 1'b0;
  endtask

  // Go via OFF so the target mode always starts from its origin; returns after the clear edge.
  task automatic restart(input logic [1:0] m, input logic [3:0] sp);
    mode    = MODE_OFF;
    speed   = sp;
    exp_gap = gap_of(int'(sp));
    repeat (2) @(posedge clk50);
    #1 mode = m;
    @(posedge clk50);
    #1;
  endtask

  task automatic wait_tick(input int bound, output int n);
    n = 0;
    do begin
      @(negedge clk50);
      n++;
    end while (!tick && n < bound);
    chk("tick_seen", tick, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k_max;
    logic [3:0] sp;

    // Reset state and release latency
    #23;
    chk("rst_leds", leds, 0);
    chk("rst_blink", blink, 0);
    chk("rst_tick", tick, 0);
    @(negedge clk50) rst_n = 1'b1;
    wait_tick(40, n);
    chk("first_tick_latency", n, 16);

    // BINARY straight from reset, random speed; blink checked against wrap count
    @(posedge clk50);
    #1;
    speed   = 4'($urandom_range(0, 15));
    exp_gap = gap_of(int'(speed));
    k_max   = $urandom_range(20, 28);
    for (int k = 2; k <= k_max; k++) push(0, k % 16, (k / 16) % 2);
    mon_en = 1'b1;
    drain(k_max * 20 + 40);

    // Asynchronous reset while tick is high and blink is set
    wait_tick(40, n);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_leds", leds, 0);
    chk("async_rst_blink", blink, 0);
    chk("async_rst_tick", tick, 0);
    speed = 4'd0;
    mode  = MODE_BINARY;
    @(negedge clk50) rst_n = 1'b1;
    wait_tick(40, n);
    chk("rerelease_latency", n, 16);

    // BINARY->CHASE switch at leds=0110 with a coincident tick
    @(posedge clk50);
    #1 speed = 4'd2;
    for (int i = 0; i < 5; i++) wait_tick(40, n);
    repeat (4) @(posedge clk50);
    #1;
    chk("switch_tick_coincident", tick, 1);
    chk("switch_pre_leds", leds, 4'b0110);
    mode = MODE_CHASE;
    repeat (2) @(posedge clk50);
    #1;
    chk("switch_origin", leds, 4'b0001);
    wait_tick(40, n);
    chk("switch_hold", leds, 4'b0001);
    repeat (2) @(posedge clk50);
    #1;
    chk("switch_first_step", leds, 4'b0010);

    // Random CHASE run
    sp = 4'($urandom_range(0, 15));
    restart(MODE_CHASE, sp);
    k_max = $urandom_range(8, 16);
    for (int k = 1; k <= k_max; k++) push(0, chase_leds(k), -1);
    mon_en = 1'b1;
    drain(k_max * 20 + 40);

    // Random BINARY run after a mode change (counts from origin)
    sp = 4'($urandom_range(0, 15));
    restart(MODE_BINARY, sp);
    k_max = $urandom_range(10, 20);
    for (int k = 1; k <= k_max; k++) push(0, k % 16, -1);
    mon_en = 1'b1;
    drain(k_max * 20 + 40);

    // BREATHE at speed 0: each tick window spans one full PWM period
    restart(MODE_BREATHE, 4'd0);
    for (int k = 1; k <= 32; k++) push(1, breathe_eff(k), -1);
    mon_en = 1'b1;
    drain(40 * 17);

    // OFF with speed clamped: leds dark, tick still every 2 clocks
    restart(MODE_OFF, 4'd15);
    for (int k = 1; k <= 10; k++) push(0, 0, -1);
    mon_en = 1'b1;
    drain(200);

    // Speed 0->3 while presc=10: tick on the very next clock
    speed = 4'd0;
    wait_tick(40, n);
    repeat (10) @(posedge clk50);
    #1 speed = 4'd3;
    @(negedge clk50);
    chk("speedup_no_early_tick", tick, 0);
    @(negedge clk50);
    chk("speedup_tick", tick, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
